// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared widths and store-controller state encoding
package soc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } st_state_e;

    function automatic logic st_is_busy(input st_state_e s);
        return (s == ST_SETUP) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - wait-state counter with terminal count at TIMEOUT-1
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/acc_store_ctrl.sv
// rtl/acc_store_ctrl.sv - captures accumulator value and writes it to data memory
module acc_store_ctrl
    import soc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] acc_data,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready
);

    st_state_e state;
    st_state_e state_next;
    logic      timer_clear;
    logic      timer_en;
    logic      timer_tc;

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mem_ready wins over the timeout when both land in the same cycle
    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (st_req) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next  = ST_WRITE;
                timer_clear = 1'b1;
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    state_next = ST_DONE;
                end else if (timer_tc) begin
                    state_next = ST_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are flops aligned with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            st_busy   <= 1'b0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            st_busy <= st_is_busy(state_next);
            st_done <= (state_next == ST_DONE);
            st_err  <= (state_next == ST_ERR);
            mem_we  <= (state_next == ST_WRITE);
            if (state == ST_IDLE && st_req) begin
                mem_addr  <= st_addr;
                mem_wdata <= acc_data;
            end
        end
    end

endmodule

// File: doc/acc_store_ctrl.md
Name: acc_store_ctrl

Overview:
- Read side of the accumulator: takes the current `acc_out` value and writes it to the data-memory bus on a store request from the control unit.
- Captures address and data at request time, then runs a write handshake with wait states and a timeout.
- Reports done/error to the sequencer.
- Sits between the accumulator, the control unit and the data memory in the CISC datapath.

Parameters:
- DATA_W, 8, accumulator/data width.
- ADDR_W, 8, memory address width.
- TIMEOUT, 15, maximum WRITE cycles waiting for mem_ready before error (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- st_req  in  1  store request from control unit; sampled only in IDLE.
- st_addr  in  ADDR_W  target address, captured with st_req.
- acc_data  in  DATA_W  accumulator output, captured with st_req.
- st_busy  out  1  high in SETUP and WRITE.
- st_done  out  1  one-cycle pulse on successful write.
- st_err  out  1  one-cycle pulse on timeout.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_wdata  out  DATA_W  registered write data.
- mem_we  out  1  write enable; high only in WRITE.
- mem_ready  in  1  memory accepts write in the current cycle.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state=IDLE; all outputs 0; wait counter 0.
- Reset asserted mid-operation drops mem_we at the next edge with no done/err pulse.
- States: IDLE, SETUP, WRITE, DONE, ERR; all outputs registered.
- IDLE:
  - st_busy=0, mem_we=0.
  - st_req=1 at an edge: capture st_addr into mem_addr and acc_data into mem_wdata, go to SETUP.
- SETUP (exactly 1 cycle):
  - mem_addr/mem_wdata stable, mem_we=0, st_busy=1.
  - Next state WRITE; wait counter cleared to 0.
- WRITE:
  - mem_we=1, st_busy=1.
  - mem_ready=1 at an edge: go to DONE.
  - Else if counter==TIMEOUT-1: go to ERR.
  - Else counter+1.
  - mem_ready has priority over timeout in the same cycle.
- DONE: st_done=1, mem_we=0, st_busy=0, for 1 cycle; then IDLE.
- ERR: st_err=1, mem_we=0, st_busy=0, for 1 cycle; then IDLE.
- Latency: request sampled at edge E0; SETUP in cycle 1; WRITE from cycle 2; with zero wait states st_done is high in cycle 3.
- Number of WRITE cycles with mem_we=1 = wait states + 1; on timeout, exactly TIMEOUT cycles.
- st_req outside IDLE (including DONE/ERR) is ignored, not queued; the control unit re-requests.
- Changes on acc_data/st_addr after capture do not affect mem_wdata/mem_addr.
- mem_addr/mem_wdata hold their last captured values after DONE/ERR until the next capture.
- Wait counter width: clog2(TIMEOUT)+1 bits; no wrap possible.

Decomposition:
- Shared package soc_pkg:
  - DATA_W, ADDR_W defaults.
  - State encoding constants ST_IDLE, ST_SETUP, ST_WRITE, ST_DONE, ST_ERR (3 bits).
- One sub-module is natural: wait_timer (clear, enable, terminal-count output, parameter TIMEOUT).
- The FSM and capture registers stay in acc_store_ctrl.

Test Plan:
1. Zero-wait write:
   - Stimulus: reset 2 cycles; st_req=1 for one cycle, st_addr=8'h40, acc_data=8'h1A; mem_ready tied 1.
   - Response: mem_we high exactly 1 cycle (cycle 2) with mem_addr=8'h40, mem_wdata=8'h1A; st_done pulse in cycle 3; st_busy high cycles 1-2.
2. Wait states:
   - Stimulus: st_addr=8'h22, acc_data=8'h82; mem_ready held 0 for 3 WRITE cycles, then 1.
   - Response: mem_we high 4 cycles; st_done in the following cycle; st_err stays 0.
3. Timeout:
   - Stimulus: TIMEOUT=15, mem_ready held 0.
   - Response: mem_we high exactly 15 cycles; st_err pulse 1 cycle; st_done never high.
   - Repeat with mem_ready=1 in the 15th WRITE cycle: st_done, no st_err.
4. Request while busy:
   - Stimulus: second st_req with st_addr=8'h84, acc_data=8'hA6 during WRITE and during DONE.
   - Response: ignored; mem_addr/mem_wdata keep 8'h40/8'h1A.
   - A later request in IDLE is accepted normally.
5. Capture isolation:
   - Stimulus: acc_data changes to 8'h83 one cycle after capture of 8'h42.
   - Response: mem_wdata=8'h42 throughout WRITE.
6. Reset mid-write:
   - Stimulus: reset=1 during the second WRITE cycle.
   - Response: at the next edge mem_we=0, all outputs 0, state IDLE; no st_done/st_err pulse.
